exp_series_ctrl: RTL and testbench

Sequencing controller for the fixed-point Taylor-series exponent datapath: 16-bit registers, adder/subtractor, 16x16 multiplier, operand mux and the 1/n reciprocal LUT. It accepts a start request, drives the datapath through TERMS iterations of term = term·x·(1/n) and acc = acc ± term, then signals completion. It holds no arithmetic of its own. It only owns the term index, the FSM and the handshake/status flags.

---
 rtl/exp_series_ctrl_if.sv | 29 ++
 rtl/exp_series_ctrl.sv | 164 ++++++++++++++++
 tb/tb_exp_series_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/exp_series_ctrl_if.sv
// Handshake and datapath-control bundle between the exponent sequencer and its datapath.
interface exp_series_ctrl_if;
  logic       start;
  logic       neg;
  logic       abort;
  logic       co;
  logic       ld_x;
  logic       ld_term;
  logic       ld_acc;
  logic       init_sel;
  logic       mul_sel;
  logic       add_mode;
  logic [3:0] lut_addr;
  logic       busy;
  logic       done;
  logic       ovf;

  // Sequencer side: consumes requests/carry, drives the datapath controls and status.
  modport master (
    input  start, neg, abort, co,
    output ld_x, ld_term, ld_acc, init_sel, mul_sel, add_mode, lut_addr, busy, done, ovf
  );

  // Requester/datapath side.
  modport slave (
    output start, neg, abort, co,
    input  ld_x, ld_term, ld_acc, init_sel, mul_sel, add_mode, lut_addr, busy, done, ovf
  );
endinterface

// File: rtl/exp_series_ctrl.sv
// Sequencer for the Taylor-series exponent datapath: term index, FSM and status flags.
module exp_series_ctrl #(
  parameter int unsigned TERMS = 8
) (
  input logic               clk,
  input logic               rst,
  exp_series_ctrl_if.master bus
);

  localparam int unsigned IDX_W = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TERMS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MUL_X = 3'd2,
    MUL_R = 3'd3,
    ACC   = 3'd4,
    DONE  = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              neg_q, neg_d;
  logic              ovf_q, ovf_d;
  logic              acc_add_c;

  logic ld_x_q, ld_x_d;
  logic ld_term_q, ld_term_d;
  logic ld_acc_q, ld_acc_d;
  logic init_sel_q, init_sel_d;
  logic mul_sel_q, mul_sel_d;
  logic add_mode_q, add_mode_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  // Current ACC direction: odd powers subtract when computing e^-x.
  assign acc_add_c = ~(neg_q & ~idx_q[0]);

  // Next-state, index and flag update; abort overrides every transition.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            neg_d   = bus.neg;
            state_d = LOAD;
          end
        end
        LOAD: begin
          idx_d   = '0;
          ovf_d   = 1'b0;
          state_d = MUL_X;
        end
        MUL_X: state_d = MUL_R;
        MUL_R: state_d = ACC;
        ACC: begin
          if (acc_add_c && bus.co) begin
            ovf_d = 1'b1;
          end
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = MUL_X;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Moore output decode of the upcoming state so the controls come straight from flops.
  always_comb begin
    ld_x_d     = 1'b0;
    ld_term_d  = 1'b0;
    ld_acc_d   = 1'b0;
    init_sel_d = 1'b0;
    mul_sel_d  = 1'b0;
    add_mode_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    case (state_d)
      LOAD: begin
        ld_x_d     = 1'b1;
        ld_term_d  = 1'b1;
        ld_acc_d   = 1'b1;
        init_sel_d = 1'b1;
        busy_d     = 1'b1;
      end
      MUL_X: begin
        ld_term_d = 1'b1;
        busy_d    = 1'b1;
      end
      MUL_R: begin
        ld_term_d = 1'b1;
        mul_sel_d = 1'b1;
        busy_d    = 1'b1;
      end
      ACC: begin
        ld_acc_d   = 1'b1;
        add_mode_d = ~(neg_d & ~idx_d[0]);
        busy_d     = 1'b1;
      end
      DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // State, index, flags and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      neg_q      <= 1'b0;
      ovf_q      <= 1'b0;
      ld_x_q     <= 1'b0;
      ld_term_q  <= 1'b0;
      ld_acc_q   <= 1'b0;
      init_sel_q <= 1'b0;
      mul_sel_q  <= 1'b0;
      add_mode_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      neg_q      <= neg_d;
      ovf_q      <= ovf_d;
      ld_x_q     <= ld_x_d;
      ld_term_q  <= ld_term_d;
      ld_acc_q   <= ld_acc_d;
      init_sel_q <= init_sel_d;
      mul_sel_q  <= mul_sel_d;
      add_mode_q <= add_mode_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.ld_x     = ld_x_q;
  assign bus.ld_term  = ld_term_q;
  assign bus.ld_acc   = ld_acc_q;
  assign bus.init_sel = init_sel_q;
  assign bus.mul_sel  = mul_sel_q;
  assign bus.add_mode = add_mode_q;
  assign bus.lut_addr = idx_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_exp_series_ctrl.sv
// Directed self-checking bench for exp_series_ctrl with a small Q8.8 datapath model.
module tb_exp_series_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  exp_series_ctrl_if i8 ();
  exp_series_ctrl_if i1 ();
  exp_series_ctrl_if i16 ();

  exp_series_ctrl #(.TERMS(8))  dut8  (.clk(clk), .rst(rst), .bus(i8));
  exp_series_ctrl #(.TERMS(1))  dut1  (.clk(clk), .rst(rst), .bus(i1));
  exp_series_ctrl #(.TERMS(16)) dut16 (.clk(clk), .rst(rst), .bus(i16));

  always #5 clk = ~clk;

  // Datapath model: Q8.8 registers, reciprocal LUT in Q0.16 with rounding.
  logic [15:0] x_in, x_r, term_r, acc_r;

  function automatic longint recip(input logic [3:0] a);
    longint n;
    n = longint'(a) + 1;
    return (65536 + n / 2) / n;
  endfunction

  always @(posedge clk) begin
    if (i8.ld_x) x_r <= x_in;
    if (i8.ld_term) begin
      if (i8.init_sel)     term_r <= 16'h0100;
      else if (i8.mul_sel) term_r <= 16'((longint'(term_r) * recip(i8.lut_addr) + 32768) >>> 16);
      else                 term_r <= 16'((longint'(term_r) * longint'(x_r)) >>> 8);
    end
    if (i8.ld_acc) begin
      if (i8.init_sel)     acc_r <= 16'h0100;
      else if (i8.add_mode) acc_r <= acc_r + term_r;
      else                 acc_r <= acc_r - term_r;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [13:0] outs8();
    return {i8.ld_x, i8.ld_term, i8.ld_acc, i8.init_sel, i8.mul_sel, i8.add_mode,
            i8.lut_addr, i8.busy, i8.done, i8.ovf};
  endfunction

  // One run on the TERMS=8 instance, sampling every cycle at the falling edge.
  task automatic run8(input logic neg_in, input int abort_cyc, input int co_acc, input bit poke,
                      output int busy_cnt, output int done_cnt, output logic done_last,
                      output logic [7:0] am, output logic [31:0] addrs);
    int acc_i;
    int mr_i;
    busy_cnt = 0; done_cnt = 0; done_last = 1'b0; am = '0; addrs = '0;
    acc_i = 0; mr_i = 0;
    i8.start = 1'b1;
    i8.neg   = neg_in;
    @(negedge clk);
    for (int c = 0; c < 200; c++) begin
      i8.start = 1'b0; i8.abort = 1'b0; i8.co = 1'b0;
      if (!i8.busy) break;
      busy_cnt++;
      done_cnt += int'(i8.done);
      done_last = i8.done;
      if (i8.ld_acc && !i8.init_sel) begin
        if (acc_i < 8) am[acc_i] = i8.add_mode;
        if (acc_i == co_acc) i8.co = 1'b1;
        acc_i++;
      end
      if (i8.mul_sel) begin
        if (mr_i < 8) addrs[4*mr_i +: 4] = i8.lut_addr;
        mr_i++;
      end
      if (busy_cnt == abort_cyc) i8.abort = 1'b1;
      if (poke && ((busy_cnt % 5) == 0 || i8.done)) i8.start = 1'b1;
      @(negedge clk);
    end
    if (i8.busy) chk("run8_timeout", 32'(i8.busy), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          bc, dc;
    logic        dl;
    logic [7:0]  am;
    logic [31:0] ad;
    logic [59:0] bv;
    int          zeros, z0, z1, found, b1, b16, mr16;
    logic [3:0]  last_addr;

    i8.start = 0;  i8.neg = 0;  i8.abort = 0;  i8.co = 0;
    i1.start = 0;  i1.neg = 0;  i1.abort = 0;  i1.co = 0;
    i16.start = 0; i16.neg = 0; i16.abort = 0; i16.co = 0;
    x_in = 16'h0100;
    rst  = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs", 32'(outs8()), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Nominal e^x with x = 1.0
    run8(1'b0, -1, -1, 1'b0, bc, dc, dl, am, ad);
    chk("ex_busy_cycles", 32'(bc), 32'd26);
    chk("ex_done_count", 32'(dc), 32'd1);
    chk("ex_done_last", 32'(dl), 32'd1);
    chk("ex_add_modes", 32'(am), 32'h0000_00FF);
    chk("ex_lut_addrs", ad, 32'h7654_3210);
    chk("ex_acc_value", 32'(acc_r), 32'h0000_02B8);
    chk("ex_ovf_clear", 32'(i8.ovf), 32'd0);

    // e^-x: alternating subtract/add
    run8(1'b1, -1, -1, 1'b0, bc, dc, dl, am, ad);
    chk("enx_add_modes", 32'(am), 32'h0000_00AA);
    chk("enx_busy_cycles", 32'(bc), 32'd26);

    // co during a subtract ACC must not flag overflow
    run8(1'b1, -1, 0, 1'b0, bc, dc, dl, am, ad);
    chk("ovf_sub_ignored", 32'(i8.ovf), 32'd0);

    // co during an add ACC sets sticky ovf until the next LOAD
    run8(1'b0, -1, 3, 1'b0, bc, dc, dl, am, ad);
    chk("ovf_set", 32'(i8.ovf), 32'd1);
    repeat (3) @(negedge clk);
    chk("ovf_sticky_idle", 32'(i8.ovf), 32'd1);
    run8(1'b0, -1, -1, 1'b0, bc, dc, dl, am, ad);
    chk("ovf_cleared_by_load", 32'(i8.ovf), 32'd0);

    // Abort in cycle 10 after an overflowing first ACC
    run8(1'b0, 10, 0, 1'b0, bc, dc, dl, am, ad);
    chk("abort_busy_cycles", 32'(bc), 32'd10);
    chk("abort_no_done", 32'(dc), 32'd0);
    chk("abort_ovf_kept", 32'(i8.ovf), 32'd1);

    // abort wins over start in IDLE
    i8.start = 1'b1; i8.abort = 1'b1;
    @(negedge clk);
    i8.start = 1'b0; i8.abort = 1'b0;
    chk("abort_over_start", 32'(i8.busy), 32'd0);
    @(negedge clk);

    // start pulses while busy and in DONE are ignored
    run8(1'b0, -1, -1, 1'b1, bc, dc, dl, am, ad);
    chk("poke_busy_cycles", 32'(bc), 32'd26);
    chk("poke_done_count", 32'(dc), 32'd1);
    @(negedge clk);
    chk("poke_no_restart", 32'(i8.busy), 32'd0);

    // start held high: runs separated by exactly one IDLE cycle
    i8.start = 1'b1; i8.neg = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 60; i++) begin
      bv[i] = i8.busy;
      @(negedge clk);
    end
    i8.start = 1'b0;
    zeros = 0; z0 = -1; z1 = -1;
    for (int i = 0; i < 60; i++) begin
      if (!bv[i]) begin
        zeros++;
        if (z0 < 0) z0 = i; else if (z1 < 0) z1 = i;
      end
    end
    chk("held_idle_count", 32'(zeros), 32'd2);
    chk("held_first_gap", 32'(z0), 32'd26);
    chk("held_second_gap", 32'(z1), 32'd53);
    for (int c = 0; c < 100 && i8.busy; c++) @(negedge clk);

    // Reset mid-run during MUL_R with idx = 3
    i8.start = 1'b1;
    @(negedge clk);
    i8.start = 1'b0;
    found = 0;
    for (int c = 0; c < 100; c++) begin
      if (i8.mul_sel && i8.lut_addr == 4'd3) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    chk("find_mulr_idx3", 32'(found), 32'd1);
    rst = 1'b0;
    #1;
    chk("async_reset_outs", 32'(outs8()), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    b1 = 0; dc = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      b1 += int'(i8.busy);
      dc += int'(i8.done);
    end
    chk("post_reset_idle_busy", 32'(b1), 32'd0);
    chk("post_reset_no_done", 32'(dc), 32'd0);

    // Boundary TERMS = 1 and TERMS = 16 run side by side
    i1.start = 1'b1; i16.start = 1'b1;
    @(negedge clk);
    i1.start = 1'b0; i16.start = 1'b0;
    b1 = 0; b16 = 0; mr16 = 0; last_addr = '0;
    for (int c = 0; c < 100; c++) begin
      if (!i1.busy && !i16.busy) break;
      b1  += int'(i1.busy);
      b16 += int'(i16.busy);
      if (i16.mul_sel) begin
        last_addr = i16.lut_addr;
        mr16++;
      end
      @(negedge clk);
    end
    chk("t1_busy_cycles", 32'(b1), 32'd5);
    chk("t16_busy_cycles", 32'(b16), 32'd50);
    chk("t16_last_lut_addr", 32'(last_addr), 32'd15);
    chk("t16_mulr_count", 32'(mr16), 32'd16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
